cv32e40p_mac_accumulator: RTL and testbench
===========================================

Name: cv32e40p_mac_accumulator

Overview:
Multi-channel, pipelined fixed-point multiply-accumulate unit for the CNN datapath: signed DATA_W operands in Q(DATA_W-FRAC_W).FRAC_W format, rounded product, saturating wide accumulation per channel. Successor to the single-channel cumulative unit. Adds configurable width and fraction, N_CH independent accumulators, valid/ready handshake, saturation with sticky flags, optional ReLU, and auto-clear on last beat. Sits between the CNN operand fetch logic and the activation writeback.

Parameters:
DATA_W, 32, operand and result width (signed).
FRAC_W, 16, fractional bits of operands and result; 1 <= FRAC_W < DATA_W.
ACC_W, 40, accumulator width; ACC_W >= DATA_W.
N_CH, 4, number of independent accumulator channels; >= 1.

Ports:
clk_i  in  1  clock.
rst_n_global_i  in  1  reset, asynchronous, active-low.
clr_i  in  1  synchronous clear of all channels, pipeline and flags.
valid_i  in  1  input beat valid.
ready_o  out  1  input beat accepted when valid_i && ready_o.
ch_i  in  max(1,$clog2(N_CH))  target channel of beat.
a_i  in  DATA_W  signed operand A.
b_i  in  DATA_W  signed operand B.
last_i  in  1  final beat of this channel's dot product.
relu_i  in  1  apply ReLU to this result (sampled with last beat).
out_valid_o  out  1  result valid.
out_ready_i  in  1  result consumed when out_valid_o && out_ready_i.
out_ch_o  out  width of ch_i  channel of result.
out_data_o  out  DATA_W  signed result.
out_sat_o  out  1  result saturated (accumulator or output narrowing).
sat_o  out  N_CH  sticky per-channel saturation flags.

Behaviour:
- Reset (async, rst_n_global_i=0): all accumulators 0, S1 valid 0, out_valid_o 0, out_data_o 0, out_ch_o 0, out_sat_o 0, sat_o 0. ready_o=1 after reset is released.
- stall = out_valid_o && !out_ready_i. ready_o = !stall. While stalled, S1 and S2 hold all state. Accumulators are unchanged.
- S1 (edge after accept): p = a_i*b_i (2*DATA_W signed). Round half up: r = (p + 2^(FRAC_W-1)) >>> FRAC_W (arithmetic). Saturate r to ACC_W signed. Register r, ch, last, relu and the product-saturation bit.
- S2 (next edge, S1 valid, no stall): s = acc[ch] + r, saturating to ACC_W. Any saturation in S1 or S2 sets sat_o[ch] and the pending-sat bit of the channel.
  - Not last: acc[ch] <= s.
  - Last: acc[ch] <= 0. out_data_o <= s saturated to DATA_W. If relu and s<0, out_data_o <= 0. out_sat_o <= pending-sat OR narrowing-sat. Pending-sat[ch] is cleared. out_ch_o <= ch. out_valid_o <= 1.
- Latency: last beat accepted in cycle t gives out_valid_o in cycle t+2. Throughput is 1 beat/cycle when out_ready_i=1.
- out_valid_o falls on the handshake unless a new last result is written on the same edge. Back-to-back results are then allowed.
- Same channel on consecutive beats: no hazard. Only S2 reads and writes acc, in one cycle.
- Channels are fully independent; beats may interleave arbitrarily. ch_i >= N_CH: the beat is accepted and dropped (no acc, flag or output change).
- clr_i=1: all acc, pending-sat and sat_o go to 0, S1 valid 0, out_valid_o 0. A beat presented in the same cycle is discarded. clr_i has priority over stall and handshake. ready_o stays !stall and is evaluated after the clear.
- Reset or clr mid-accumulation abandons partial sums. No output is produced for them.
- sat_o is cleared only by reset or clr_i.

Test Plan:
- Q16.16 dot product on ch0: (2.0,1.5) x3, i.e. a=0x00020000, b=0x00018000, last on the 3rd beat in cycle t -> out_valid_o at t+2, out_data_o=0x00090000, out_sat_o=0. The next dot product on ch0 starts from 0.
- Rounding: a=1, b=0x8000, last -> out_data_o=1. a=-1 (0xFFFFFFFF), b=0x8000, last -> out_data_o=0.
- Saturation: a=b=0x01000000 (256.0), last -> out_data_o=0x7FFFFFFF, out_sat_o=1, sat_o[ch]=1. Negative case a=0xFF000000 -> 0x80000000. With relu_i=1, the negative case gives out_data_o=0 and out_sat_o=1.
- Interleave: alternate ch0 (1.0,1.0) and ch1 (1.0,-1.0), 4 beats each -> results ch0=0x00040000 and ch1=0xFFFC0000, emitted in last-beat order.
- Backpressure: hold out_ready_i=0 for 5 cycles with a result pending -> ready_o=0, outputs stable. After release, all results are delivered in order with correct values and no loss or duplication.
- clr_i and async reset asserted mid-accumulation on ch2 -> no output, acc and sat_o zero. The subsequent dot product (1.0x1.0, last) gives 0x00010000.

Source files
------------

// File: rtl/cv32e40p_mac_accumulator.sv
// Multi-channel pipelined Q-format multiply-accumulate unit.
// S1 forms the rounded product, S2 accumulates per channel and emits results on the last beat.
module cv32e40p_mac_accumulator #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned FRAC_W = 16,
    parameter int unsigned ACC_W  = 40,
    parameter int unsigned N_CH   = 4,
    localparam int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk_i,
    input  logic              rst_n_global_i,
    input  logic              clr_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [CH_W-1:0]   ch_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              last_i,
    input  logic              relu_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CH_W-1:0]   out_ch_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_sat_o,
    output logic [N_CH-1:0]   sat_o
);

    localparam int unsigned PW = 2 * DATA_W + 1;

    logic                     w_stall;
    logic                     w_accept;
    logic signed [2*DATA_W-1:0] w_a_ext;
    logic signed [2*DATA_W-1:0] w_b_ext;
    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [PW-1:0]     w_prod_rnd;
    logic signed [PW-1:0]     w_prod_shr;
    logic                     w_s1_ovf;
    logic [ACC_W-1:0]         w_r_sat;

    logic                     r_s1_valid;
    logic [ACC_W-1:0]         r_s1_r;
    logic [CH_W-1:0]          r_s1_ch;
    logic                     r_s1_last;
    logic                     r_s1_relu;
    logic                     r_s1_sat;

    logic [ACC_W-1:0]         r_acc [N_CH];
    logic [N_CH-1:0]          r_pend_sat;
    logic [N_CH-1:0]          r_sat;

    logic                     w_s2_fire;
    logic [ACC_W-1:0]         w_acc_cur;
    logic [ACC_W:0]           w_sum;
    logic                     w_s2_ovf;
    logic [ACC_W-1:0]         w_s;
    logic                     w_nar_ovf;
    logic [DATA_W-1:0]        w_narrow;
    logic [DATA_W-1:0]        w_res;
    logic                     w_beat_sat;

    logic                     r_out_valid;
    logic [CH_W-1:0]          r_out_ch;
    logic [DATA_W-1:0]        r_out_data;
    logic                     r_out_sat;

    assign w_stall  = r_out_valid && !out_ready_i;
    assign ready_o  = !w_stall;
    // Out-of-range channels are accepted but never enter the pipeline.
    assign w_accept = valid_i && !w_stall && !clr_i && (32'(ch_i) < N_CH);

    assign w_a_ext    = $signed({{DATA_W{a_i[DATA_W-1]}}, a_i});
    assign w_b_ext    = $signed({{DATA_W{b_i[DATA_W-1]}}, b_i});
    assign w_prod     = w_a_ext * w_b_ext;
    assign w_prod_rnd = $signed({w_prod[2*DATA_W-1], w_prod}) + (PW'(1) << (FRAC_W - 1));
    assign w_prod_shr = w_prod_rnd >>> FRAC_W;
    assign w_s1_ovf   = !((&w_prod_shr[PW-1:ACC_W-1]) || !(|w_prod_shr[PW-1:ACC_W-1]));
    assign w_r_sat    = w_s1_ovf ? {w_prod_shr[PW-1], {(ACC_W-1){~w_prod_shr[PW-1]}}}
                                 : w_prod_shr[ACC_W-1:0];

    always_ff @(posedge clk_i or negedge rst_n_global_i) begin
        if (!rst_n_global_i) begin
            r_s1_valid <= 1'b0;
            r_s1_r     <= '0;
            r_s1_ch    <= '0;
            r_s1_last  <= 1'b0;
            r_s1_relu  <= 1'b0;
            r_s1_sat   <= 1'b0;
        end else if (clr_i) begin
            r_s1_valid <= 1'b0;
        end else if (!w_stall) begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_r    <= w_r_sat;
                r_s1_ch   <= ch_i;
                r_s1_last <= last_i;
                r_s1_relu <= relu_i;
                r_s1_sat  <= w_s1_ovf;
            end
        end
    end

    assign w_s2_fire = r_s1_valid && !w_stall;
    assign w_acc_cur = r_acc[r_s1_ch];
    assign w_sum     = {w_acc_cur[ACC_W-1], w_acc_cur} + {r_s1_r[ACC_W-1], r_s1_r};
    assign w_s2_ovf  = w_sum[ACC_W] ^ w_sum[ACC_W-1];
    assign w_s       = w_s2_ovf ? {w_sum[ACC_W], {(ACC_W-1){~w_sum[ACC_W]}}}
                                : w_sum[ACC_W-1:0];
    assign w_nar_ovf = !((&w_s[ACC_W-1:DATA_W-1]) || !(|w_s[ACC_W-1:DATA_W-1]));
    assign w_narrow  = w_nar_ovf ? {w_s[ACC_W-1], {(DATA_W-1){~w_s[ACC_W-1]}}}
                                 : w_s[DATA_W-1:0];
    assign w_res     = (r_s1_relu && w_s[ACC_W-1]) ? '0 : w_narrow;
    // Narrowing only matters on the last beat, where the sum leaves the block.
    assign w_beat_sat = r_s1_sat || w_s2_ovf || (r_s1_last && w_nar_ovf);

    always_ff @(posedge clk_i or negedge rst_n_global_i) begin
        if (!rst_n_global_i) begin
            for (int i = 0; i < int'(N_CH); i++) begin
                r_acc[i] <= '0;
            end
            r_pend_sat <= '0;
            r_sat      <= '0;
        end else if (clr_i) begin
            for (int i = 0; i < int'(N_CH); i++) begin
                r_acc[i] <= '0;
            end
            r_pend_sat <= '0;
            r_sat      <= '0;
        end else if (w_s2_fire) begin
            r_acc[r_s1_ch] <= r_s1_last ? '0 : w_s;
            if (w_beat_sat) begin
                r_sat[r_s1_ch] <= 1'b1;
            end
            if (r_s1_last) begin
                r_pend_sat[r_s1_ch] <= 1'b0;
            end else if (w_beat_sat) begin
                r_pend_sat[r_s1_ch] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_global_i) begin
        if (!rst_n_global_i) begin
            r_out_valid <= 1'b0;
            r_out_ch    <= '0;
            r_out_data  <= '0;
            r_out_sat   <= 1'b0;
        end else if (clr_i) begin
            r_out_valid <= 1'b0;
        end else if (w_s2_fire && r_s1_last) begin
            r_out_valid <= 1'b1;
            r_out_ch    <= r_s1_ch;
            r_out_data  <= w_res;
            r_out_sat   <= r_pend_sat[r_s1_ch] || w_beat_sat;
        end else if (r_out_valid && out_ready_i) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid_o = r_out_valid;
    assign out_ch_o    = r_out_ch;
    assign out_data_o  = r_out_data;
    assign out_sat_o   = r_out_sat;
    assign sat_o       = r_sat;

endmodule

// File: tb/tb_cv32e40p_mac_accumulator.sv
// Directed bench for cv32e40p_mac_accumulator: vector table plus multi-cycle corner sequences.
module tb_cv32e40p_mac_accumulator;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned FRAC_W = 16;
    localparam int unsigned ACC_W  = 40;
    localparam int unsigned N_CH   = 4;
    localparam int unsigned CH_W   = 2;

    logic              clk_i;
    logic              rst_n_global_i;
    logic              clr_i;
    logic              valid_i;
    logic              ready_o;
    logic [CH_W-1:0]   ch_i;
    logic [DATA_W-1:0] a_i;
    logic [DATA_W-1:0] b_i;
    logic              last_i;
    logic              relu_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [CH_W-1:0]   out_ch_o;
    logic [DATA_W-1:0] out_data_o;
    logic              out_sat_o;
    logic [N_CH-1:0]   sat_o;

    cv32e40p_mac_accumulator #(
        .DATA_W(DATA_W),
        .FRAC_W(FRAC_W),
        .ACC_W (ACC_W),
        .N_CH  (N_CH)
    ) u_dut (
        .clk_i         (clk_i),
        .rst_n_global_i(rst_n_global_i),
        .clr_i         (clr_i),
        .valid_i       (valid_i),
        .ready_o       (ready_o),
        .ch_i          (ch_i),
        .a_i           (a_i),
        .b_i           (b_i),
        .last_i        (last_i),
        .relu_i        (relu_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .out_ch_o      (out_ch_o),
        .out_data_o    (out_data_o),
        .out_sat_o     (out_sat_o),
        .sat_o         (sat_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  ch;
        logic        last;
        logic        relu;
        logic [31:0] exp_data;
        logic        exp_sat;
    } vec_t;

    typedef struct {
        logic [1:0]  ch;
        logic [31:0] data;
        logic        sat;
    } res_t;

    vec_t vecs [17];
    res_t exp_q [$];
    res_t mon_e;
    int   total = 0;
    int   bad   = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Scoreboard: every handshaken result must match the next expected one, in order.
    always @(negedge clk_i) begin
        if (rst_n_global_i && out_valid_o && out_ready_i) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got ch=%0d data=0x%0h, expected none",
                         out_ch_o, out_data_o);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_ch", 64'(out_ch_o), 64'(mon_e.ch));
                check("out_data", 64'(out_data_o), 64'(mon_e.data));
                check("out_sat", 64'(out_sat_o), 64'(mon_e.sat));
            end
        end
    end

    task automatic beat(input logic [31:0] a, input logic [31:0] b, input logic [1:0] ch,
                        input logic last, input logic relu, input logic [31:0] exp_data,
                        input logic exp_sat);
        int n;
        res_t r;
        if (last) begin
            r.ch   = ch;
            r.data = exp_data;
            r.sat  = exp_sat;
            exp_q.push_back(r);
        end
        a_i     = a;
        b_i     = b;
        ch_i    = ch;
        last_i  = last;
        relu_i  = relu;
        valid_i = 1'b1;
        n       = 0;
        @(negedge clk_i);
        while (!ready_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 50) begin
            check("ready_timeout", 64'(ready_o), 64'd1);
        end
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        last_i  = 1'b0;
        relu_i  = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{32'h0002_0000, 32'h0001_8000, 2'd0, 1'b0, 1'b0, 32'h0, 1'b0};
        vecs[1]  = '{32'h0002_0000, 32'h0001_8000, 2'd0, 1'b0, 1'b0, 32'h0, 1'b0};
        vecs[2]  = '{32'h0002_0000, 32'h0001_8000, 2'd0, 1'b1, 1'b0, 32'h0009_0000, 1'b0};
        vecs[3]  = '{32'h0001_0000, 32'h0001_0000, 2'd0, 1'b1, 1'b0, 32'h0001_0000, 1'b0};
        vecs[4]  = '{32'h0000_0001, 32'h0000_8000, 2'd0, 1'b1, 1'b0, 32'h0000_0001, 1'b0};
        vecs[5]  = '{32'hFFFF_FFFF, 32'h0000_8000, 2'd0, 1'b1, 1'b0, 32'h0000_0000, 1'b0};
        vecs[6]  = '{32'h0100_0000, 32'h0100_0000, 2'd1, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1};
        vecs[7]  = '{32'hFF00_0000, 32'h0100_0000, 2'd1, 1'b1, 1'b0, 32'h8000_0000, 1'b1};
        vecs[8]  = '{32'hFF00_0000, 32'h0100_0000, 2'd1, 1'b1, 1'b1, 32'h0000_0000, 1'b1};
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) begin
                vecs[9+i] = '{32'h0001_0000, 32'h0001_0000, 2'd0, (i == 6), 1'b0,
                              32'h0004_0000, 1'b0};
            end else begin
                vecs[9+i] = '{32'h0001_0000, 32'hFFFF_0000, 2'd1, (i == 7), 1'b0,
                              32'hFFFC_0000, 1'b0};
            end
        end

        rst_n_global_i = 1'b0;
        clr_i       = 1'b0;
        valid_i     = 1'b0;
        ch_i        = '0;
        a_i         = '0;
        b_i         = '0;
        last_i      = 1'b0;
        relu_i      = 1'b0;
        out_ready_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_out_valid", 64'(out_valid_o), 64'd0);
        check("rst_out_data", 64'(out_data_o), 64'd0);
        check("rst_out_ch", 64'(out_ch_o), 64'd0);
        check("rst_out_sat", 64'(out_sat_o), 64'd0);
        check("rst_sat", 64'(sat_o), 64'd0);
        rst_n_global_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("rst_ready", 64'(ready_o), 64'd1);

        foreach (vecs[i]) begin
            beat(vecs[i].a, vecs[i].b, vecs[i].ch, vecs[i].last, vecs[i].relu,
                 vecs[i].exp_data, vecs[i].exp_sat);
        end
        repeat (4) @(posedge clk_i);
        #1;
        check("sticky_sat", 64'(sat_o), 64'h2);
        check("table_drained", 64'(exp_q.size()), 64'd0);

        // Latency: result visible two edges after the last beat is accepted.
        beat(32'h0001_0000, 32'h0002_0000, 2'd3, 1'b1, 1'b0, 32'h0002_0000, 1'b0);
        check("lat_t1_valid", 64'(out_valid_o), 64'd0);
        @(posedge clk_i);
        #1;
        check("lat_t2_valid", 64'(out_valid_o), 64'd1);
        check("lat_t2_data", 64'(out_data_o), 64'h0002_0000);
        @(posedge clk_i);
        #1;

        // Backpressure with three results queued behind a held output.
        out_ready_i = 1'b0;
        beat(32'h0001_0000, 32'h0001_0000, 2'd0, 1'b1, 1'b0, 32'h0001_0000, 1'b0);
        beat(32'h0002_0000, 32'h0001_0000, 2'd1, 1'b1, 1'b0, 32'h0002_0000, 1'b0);
        a_i     = 32'h0003_0000;
        b_i     = 32'h0001_0000;
        ch_i    = 2'd2;
        last_i  = 1'b1;
        valid_i = 1'b1;
        exp_q.push_back('{2'd2, 32'h0003_0000, 1'b0});
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_i);
            #1;
            check("bp_ready", 64'(ready_o), 64'd0);
            check("bp_valid", 64'(out_valid_o), 64'd1);
            check("bp_data", 64'(out_data_o), 64'h0001_0000);
            check("bp_ch", 64'(out_ch_o), 64'd0);
        end
        out_ready_i = 1'b1;
        @(negedge clk_i);
        check("bp_release_ready", 64'(ready_o), 64'd1);
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        last_i  = 1'b0;
        repeat (6) @(posedge clk_i);
        #1;
        check("bp_drained", 64'(exp_q.size()), 64'd0);

        // Clear mid-accumulation on ch2, with a last beat presented in the clear cycle.
        beat(32'h0001_0000, 32'h0001_0000, 2'd2, 1'b0, 1'b0, 32'h0, 1'b0);
        beat(32'h0001_0000, 32'h0001_0000, 2'd2, 1'b0, 1'b0, 32'h0, 1'b0);
        a_i     = 32'h0001_0000;
        b_i     = 32'h0001_0000;
        ch_i    = 2'd2;
        last_i  = 1'b1;
        valid_i = 1'b1;
        clr_i   = 1'b1;
        @(posedge clk_i);
        #1;
        clr_i   = 1'b0;
        valid_i = 1'b0;
        last_i  = 1'b0;
        check("clr_sat", 64'(sat_o), 64'd0);
        check("clr_valid", 64'(out_valid_o), 64'd0);
        repeat (3) @(posedge clk_i);
        #1;
        check("clr_no_output", 64'(out_valid_o), 64'd0);
        beat(32'h0001_0000, 32'h0001_0000, 2'd2, 1'b1, 1'b0, 32'h0001_0000, 1'b0);
        repeat (3) @(posedge clk_i);
        #1;

        // Async reset mid-accumulation, after a sticky flag was raised on ch3.
        beat(32'h7FFF_FFFF, 32'h7FFF_FFFF, 2'd3, 1'b0, 1'b0, 32'h0, 1'b0);
        beat(32'h0001_0000, 32'h0001_0000, 2'd2, 1'b0, 1'b0, 32'h0, 1'b0);
        check("acc_sat_flag", 64'(sat_o), 64'h8);
        #2;
        rst_n_global_i = 1'b0;
        #1;
        check("arst_sat", 64'(sat_o), 64'd0);
        check("arst_valid", 64'(out_valid_o), 64'd0);
        @(posedge clk_i);
        #1;
        rst_n_global_i = 1'b1;
        beat(32'h0001_0000, 32'h0001_0000, 2'd2, 1'b1, 1'b0, 32'h0001_0000, 1'b0);
        repeat (4) @(posedge clk_i);
        #1;
        check("final_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
